// File: rtl/apb_arb2_pkg.sv
// apb_arb2_pkg: shared state, owner and timeout-counter definitions for the APB arbiter.
// Imported by apb_arb2 and apb_arb2_rr.
package apb_arb2_pkg;

    localparam int TMO_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_t;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWNER_M0) ? OWNER_M1 : OWNER_M0;
    endfunction

endpackage

// File: rtl/apb_arb2_rr.sv
// apb_arb2_rr: two-way round-robin winner pick from the request pair and the last grant.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is consumed.
module apb_arb2_rr
    import apb_arb2_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_grant,
    output owner_t     winner,
    output logic       valid
);

    always_comb begin
        winner = OWNER_M0;
        valid  = |req;
        case (req)
            2'b01:   winner = OWNER_M0;
            2'b10:   winner = OWNER_M1;
            2'b11:   winner = other_owner(last_grant);
            default: winner = OWNER_M0;
        endcase
    end

endmodule

// File: rtl/apb_arb2.sv
// apb_arb2: two-requester round-robin arbiter driving one APB3 completer (IDLE/SETUP/ACCESS).
// Latency: done three cycles after req with a zero-wait completer; one IDLE cycle between transfers.
// Backpressure: ACCESS holds while PREADY=0; with APB_ARB2_TIMEOUT_EN it aborts with err after TIMEOUT_CYCLES.
module apb_arb2
    import apb_arb2_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m0_write,
    input  logic              m1_write,
    input  logic [31:0]       m0_wdata,
    input  logic [31:0]       m1_wdata,
    output logic              m0_done,
    output logic              m1_done,
    output logic [31:0]       m0_rdata,
    output logic [31:0]       m1_rdata,
    output logic              m0_err,
    output logic              m1_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [31:0]       PWDATA,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    owner_t              last_q, last_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [31:0]         pwdata_q, pwdata_d;
    logic [1:0]          done_q, done_d;
    logic [1:0]          err_q, err_d;
    logic [31:0]         rdata0_q, rdata0_d;
    logic [31:0]         rdata1_q, rdata1_d;

    owner_t              rr_winner;
    logic                rr_valid;
    logic                xfer_end;
    logic                xfer_err;
    logic [31:0]         xfer_rdata;
    logic                tmo_hit;

    apb_arb2_rr u_rr (
        .req        ({m1_req, m0_req}),
        .last_grant (last_q),
        .winner     (rr_winner),
        .valid      (rr_valid)
    );

`ifdef APB_ARB2_TIMEOUT_EN
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counter holds the number of PREADY-low ACCESS cycles already seen.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_hit   = 1'b0;
        if (state_q == IDLE && rr_valid) begin
            tmo_cnt_d = '0;
        end else if (state_q == ACCESS && !PREADY) begin
            if (tmo_cnt_q == TMO_LAST) begin
                tmo_hit = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    localparam int tmo_unused = TIMEOUT_CYCLES;

    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        paddr_d    = paddr_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        done_d     = '0;
        err_d      = '0;
        rdata0_d   = '0;
        rdata1_d   = '0;
        xfer_end   = 1'b0;
        xfer_err   = 1'b0;
        xfer_rdata = '0;

        case (state_q)
            IDLE: begin
                if (rr_valid) begin
                    state_d = SETUP;
                    owner_d = rr_winner;
                    last_d  = rr_winner;
                    if (rr_winner == OWNER_M1) begin
                        paddr_d  = m1_addr;
                        pwrite_d = m1_write;
                        pwdata_d = m1_wdata;
                    end else begin
                        paddr_d  = m0_addr;
                        pwrite_d = m0_write;
                        pwdata_d = m0_wdata;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // A completer response wins over a timeout landing on the same edge.
                if (PREADY) begin
                    xfer_end   = 1'b1;
                    xfer_err   = PSLVERR;
                    xfer_rdata = pwrite_q ? 32'd0 : PRDATA;
                end else if (tmo_hit) begin
                    xfer_end   = 1'b1;
                    xfer_err   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (xfer_end) begin
            state_d = IDLE;
            if (owner_q == OWNER_M1) begin
                done_d[1] = 1'b1;
                err_d[1]  = xfer_err;
                rdata1_d  = xfer_rdata;
            end else begin
                done_d[0] = 1'b1;
                err_d[0]  = xfer_err;
                rdata0_d  = xfer_rdata;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            owner_q  <= OWNER_M0;
            last_q   <= OWNER_M1;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            done_q   <= '0;
            err_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign PSEL     = (state_q != IDLE);
    assign PENABLE  = (state_q == ACCESS);
    assign PWRITE   = pwrite_q;
    assign PADDR    = paddr_q;
    assign PWDATA   = pwdata_q;
    assign m0_done  = done_q[0];
    assign m1_done  = done_q[1];
    assign m0_err   = err_q[0];
    assign m1_err   = err_q[1];
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_apb_arb2.sv
`timescale 1ns/1ps
// Bench for apb_arb2: directed scenarios plus random traffic, checked by a transaction-level model and scoreboard.
module tb_apb_arb2;

    localparam int AW  = 12;
    localparam int TMO = 4;

    logic            PCLK = 1'b0;
    logic            PRESETn = 1'b0;
    logic [1:0]      req;
    logic [AW-1:0]   addr [2];
    logic [1:0]      wr;
    logic [31:0]     wdata [2];
    logic            m0_done, m1_done, m0_err, m1_err;
    logic [31:0]     m0_rdata, m1_rdata;
    logic            PSEL, PENABLE, PWRITE;
    logic [AW-1:0]   PADDR;
    logic [31:0]     PWDATA;
    logic [31:0]     PRDATA;
    logic            PREADY, PSLVERR;
    logic [1:0]      done;

    assign done = {m1_done, m0_done};

    always #5 PCLK = ~PCLK;

    apb_arb2 #(.ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .m0_req(req[0]), .m1_req(req[1]),
        .m0_addr(addr[0]), .m1_addr(addr[1]),
        .m0_write(wr[0]), .m1_write(wr[1]),
        .m0_wdata(wdata[0]), .m1_wdata(wdata[1]),
        .m0_done(m0_done), .m1_done(m1_done),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_err(m0_err), .m1_err(m1_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct { int who; logic [31:0] rdata; logic err; int cyc; } exp_t;
    typedef struct { int wt; logic [31:0] data; logic err; } plan_t;

    exp_t        sb_q [$];
    plan_t       plan_q [$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [1:0]  hold;
    bit          auto_en;
    int          wait_left;
    logic [31:0] rsp_data;
    logic        rsp_err;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rdata_of(input int i);
        return (i == 1) ? m1_rdata : m0_rdata;
    endfunction

    function automatic logic err_of(input int i);
        return (i == 1) ? m1_err : m0_err;
    endfunction

    // Reference model: bus phase 0=idle,1=setup,2=access; expected completions go to sb_q.
    int            cyc = 0;
    int            m_phase = 0;
    int            m_last = 1;
    int            m_owner = 0;
    int            acc_n = 0;
    logic [AW-1:0] e_addr;
    logic          e_write;
    logic [31:0]   e_wdata;

    always @(negedge PCLK) begin
        exp_t e;
        int   w;
        cyc++;
        if (!PRESETn) begin
            sb_q.delete();
            m_phase = 0;
            m_last  = 1;
            acc_n   = 0;
        end else begin
            if (done != 2'b00) begin
                check("done_onehot", 64'($onehot(done)), 64'd1);
                w = done[1] ? 1 : 0;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_owner", 64'(w), 64'(e.who));
                    check("sb_cycle", 64'(cyc), 64'(e.cyc));
                    check("sb_rdata", 64'(rdata_of(w)), 64'(e.rdata));
                    check("sb_err", 64'(err_of(w)), 64'(e.err));
                    check("nonowner_quiet", 64'({rdata_of(1 - w), err_of(1 - w)}), 64'd0);
                end
            end else begin
                check("quiet_m0", 64'({m0_rdata, m0_err}), 64'd0);
                check("quiet_m1", 64'({m1_rdata, m1_err}), 64'd0);
                if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                    e = sb_q.pop_front();
                    check("missing_done", 64'(done), (e.who == 1) ? 64'd2 : 64'd1);
                end
            end

            check("bus_phase", 64'({PSEL, PENABLE}),
                  (m_phase == 0) ? 64'd0 : (m_phase == 1) ? 64'd2 : 64'd3);
            if (m_phase != 0)
                check("bus_fields", 64'({PADDR, PWRITE, PWDATA}), 64'({e_addr, e_write, e_wdata}));

            case (m_phase)
                0: if (req != 2'b00) begin
                    if (req == 2'b11) w = (m_last == 0) ? 1 : 0;
                    else              w = req[1] ? 1 : 0;
                    m_last  = w;
                    m_owner = w;
                    e_addr  = addr[w];
                    e_write = wr[w];
                    e_wdata = wdata[w];
                    m_phase = 1;
                end
                1: begin
                    m_phase = 2;
                    acc_n   = 0;
                end
                default: begin
                    if (PREADY) begin
                        sb_q.push_back('{m_owner, e_write ? 32'd0 : PRDATA, PSLVERR, cyc + 1});
                        m_phase = 0;
                    end else begin
                        acc_n++;
`ifdef APB_ARB2_TIMEOUT_EN
                        if (acc_n == TMO) begin
                            sb_q.push_back('{m_owner, 32'd0, 1'b1, cyc + 1});
                            m_phase = 0;
                        end
`endif
                    end
                end
            endcase
        end
    end

    task automatic issue(input int i, input logic [AW-1:0] a, input logic w, input logic [31:0] d);
        addr[i]  = a;
        wr[i]    = w;
        wdata[i] = d;
        req[i]   = 1'b1;
    endtask

    // One clock: requesters react to done, random traffic if enabled, completer responds.
    task automatic step();
        plan_t p;
        @(posedge PCLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (req[i] && done[i] && !hold[i])
                req[i] = 1'b0;
            else if (!req[i] && auto_en && $urandom_range(0, 2) == 0)
                issue(i, AW'($urandom), 1'($urandom), $urandom);
        end
        if (PSEL && !PENABLE) begin
            if (plan_q.size() > 0) begin
                p = plan_q.pop_front();
                wait_left = p.wt;
                rsp_data  = p.data;
                rsp_err   = p.err;
            end else begin
                wait_left = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 1);
                rsp_data  = $urandom;
                rsp_err   = ($urandom_range(0, 3) == 0);
            end
        end
        if (PSEL && PENABLE && wait_left == 0) begin
            PREADY  = 1'b1;
            PRDATA  = rsp_data;
            PSLVERR = rsp_err;
        end else begin
            if (PSEL && PENABLE) wait_left--;
            PREADY  = (PSEL && PENABLE) ? 1'b0 : 1'($urandom);
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom);
        end
    endtask

    task automatic reset_pulse();
        req = '0;
        #2 PRESETn = 1'b0;
        step();
        step();
        PRESETn = 1'b1;
    endtask

    task automatic wait_done(input int i, input int max, output int n, output logic ok);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < max) begin
            step();
            n++;
            if (done[i]) ok = 1'b1;
        end
    endtask

    initial begin
        int   n;
        int   nacc;
        logic ok;
        int   who [3];
        logic [31:0] rd [3];
        logic [31:0] cap_rd;
        logic cap_err;
        logic [1:0] cap_done;

        req = '0; hold = '0; auto_en = 1'b0;
        wr = '0;
        for (int i = 0; i < 2; i++) begin addr[i] = '0; wdata[i] = '0; end
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        wait_left = 0; rsp_data = '0; rsp_err = 1'b0;

        repeat (3) step();
        check("rst_bus", 64'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 64'd0);
        check("rst_outs", 64'({done, m0_err, m1_err, m0_rdata | m1_rdata}), 64'd0);

        // Single zero-wait write from m0; first arbitration on the first edge after release.
        PRESETn = 1'b1;
        plan_q.push_back('{0, 32'hDEAD_BEEF, 1'b0});
        issue(0, 12'h004, 1'b1, 32'h0000_00A5);
        step(); check("t1_setup", 64'({PSEL, PENABLE}), 64'd2);
        step(); check("t1_access", 64'({PSEL, PENABLE}), 64'd3);
        step(); check("t1_done", 64'({m0_done, m0_err, m0_rdata}), 64'h1_0000_0000 << 1);

        // Simultaneous held reads alternate m0, m1, m0.
        reset_pulse();
        hold = 2'b11;
        plan_q.push_back('{0, 32'h11, 1'b0});
        plan_q.push_back('{0, 32'h22, 1'b0});
        plan_q.push_back('{0, 32'h33, 1'b0});
        issue(0, 12'h010, 1'b0, 32'h0);
        issue(1, 12'h020, 1'b0, 32'h0);
        n = 0;
        for (int k = 0; k < 30 && n < 3; k++) begin
            step();
            if (done != 2'b00) begin
                who[n] = done[1] ? 1 : 0;
                rd[n]  = done[1] ? m1_rdata : m0_rdata;
                n++;
            end
        end
        req = '0;
        hold = '0;
        check("rr_count", 64'(n), 64'd3);
        check("rr_first", 64'({who[0], rd[0]}), {32'd0, 32'h11});
        check("rr_second", 64'({who[1], rd[1]}), {32'd1, 32'h22});
        check("rr_third", 64'({who[2], rd[2]}), {32'd0, 32'h33});
        repeat (3) step();

        // m1 read with five wait states and a slave error.
        plan_q.push_back('{5, 32'hCAFE_0037, 1'b1});
        issue(1, 12'h030, 1'b0, 32'h0);
        nacc = 0; ok = 1'b0; cap_rd = '0; cap_err = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            step();
            if (PSEL && PENABLE) nacc++;
            if (m1_done) begin ok = 1'b1; cap_rd = m1_rdata; cap_err = m1_err; end
        end
        check("wait_done_seen", 64'(ok), 64'd1);
`ifdef APB_ARB2_TIMEOUT_EN
        check("wait_access_cycles", 64'(nacc), 64'(TMO));
        check("wait_resp", 64'({cap_err, cap_rd}), {31'd0, 1'b1, 32'd0});
`else
        check("wait_access_cycles", 64'(nacc), 64'd6);
        check("wait_resp", 64'({cap_err, cap_rd}), {31'd0, 1'b1, 32'hCAFE_0037});
`endif
        repeat (2) step();

        // Dropping req after the grant still completes the transfer.
        issue(0, 12'h040, 1'b1, 32'h1234_5678);
        step();
        req[0] = 1'b0;
        wait_done(0, 10, n, ok);
        check("drop_req_done", 64'(ok), 64'd1);
        repeat (2) step();

        // Completer stuck low for 30 cycles.
        plan_q.push_back('{30, 32'h55, 1'b0});
        issue(0, 12'h050, 1'b0, 32'h0);
        ok = 1'b0; cap_rd = 32'hFFFF_FFFF; cap_err = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (m0_done) begin ok = 1'b1; cap_rd = m0_rdata; cap_err = m0_err; end
        end
`ifdef APB_ARB2_TIMEOUT_EN
        check("tmo_done", 64'({ok, cap_err, cap_rd}), {30'd0, 1'b1, 1'b1, 32'd0});
        check("tmo_idle", 64'({PSEL, PENABLE}), 64'd0);
`else
        check("stuck_access", 64'({ok, PSEL, PENABLE}), 64'd3);
        wait_done(0, 40, n, ok);
        check("stuck_release_done", 64'(ok), 64'd1);
`endif
        repeat (3) step();

        // Reset during ACCESS: bus drops at once, no done afterwards, pointer favours m0.
        reset_pulse();
        step();
        plan_q.delete();
        plan_q.push_back('{4, 32'h0, 1'b0});
        issue(0, 12'h060, 1'b1, 32'h66);
        step(); step();
        check("pre_rst_access", 64'({PSEL, PENABLE}), 64'd3);
        #2 PRESETn = 1'b0;
        #1 check("rst_async", 64'({PSEL, PENABLE, m0_done, m1_done}), 64'd0);
        req = '0;
        step(); step();
        PRESETn = 1'b1;
        n = 0;
        repeat (5) begin step(); if (done != 2'b00) n++; end
        check("rst_no_done", 64'(n), 64'd0);
        issue(0, 12'h070, 1'b0, 32'h0);
        issue(1, 12'h080, 1'b0, 32'h0);
        cap_done = '0;
        for (int k = 0; k < 10 && cap_done == 2'b00; k++) begin
            step();
            cap_done = done;
        end
        check("rst_rr_m0", 64'(cap_done), 64'd1);
        repeat (10) step();

        // Random traffic from both requesters, with two asynchronous resets mixed in.
        auto_en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            step();
            if (k == 1200 || k == 2400) begin
                #2 PRESETn = 1'b0;
                step();
                PRESETn = 1'b1;
            end
        end
        auto_en = 1'b0;
        repeat (40) step();
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_arb2.md
APB_ARB2 -- requirements
Module: apb_arb2

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, PADDR/requester address width.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 256, maximum ACCESS-phase length before abort; legal range 2..65535.
REQ-003 The block SHALL have port PCLK, input, 1, the single clock.
REQ-004 The block SHALL have port PRESETn, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports m0_req / m1_req, input, 1 each, transfer request, held high until the matching done.
REQ-006 The block SHALL have ports m0_addr / m1_addr, input, ADDR_W each, byte address.
REQ-007 The block SHALL have ports m0_write / m1_write, input, 1 each, 1 = write.
REQ-008 The block SHALL have ports m0_wdata / m1_wdata, input, 32 each, write data.
REQ-009 The block SHALL have ports m0_done / m1_done, output, 1 each, one-cycle completion pulse.
REQ-010 The block SHALL have ports m0_rdata / m1_rdata, output, 32 each, read data, valid with done.
REQ-011 The block SHALL have ports m0_err / m1_err, output, 1 each, error status, valid with done.
REQ-012 The block SHALL have ports PSEL, PENABLE and PWRITE, output, 1 each, and PADDR, output, ADDR_W, plus PWDATA, output, 32, forming the APB3 master request.
REQ-013 The block SHALL have ports PRDATA, input, 32, and PREADY and PSLVERR, input, 1 each, forming the APB3 completer response.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP and ACCESS.
- IDLE: PSEL=0 and PENABLE=0.
- SETUP: PSEL=1 and PENABLE=0.
- ACCESS: PSEL=1 and PENABLE=1.
REQ-015 In IDLE, when either req is high, the block SHALL choose a winner, register that requester's addr/write/wdata into PADDR/PWRITE/PWDATA, record the owner, and enter SETUP on the next edge.
REQ-016 When exactly one req is high, that requester SHALL be the winner.
REQ-017 When both reqs are high, the winner SHALL be the requester not granted last (round-robin); after reset the pointer SHALL favour m0.
REQ-018 SETUP SHALL always advance to ACCESS after exactly one cycle.
REQ-019 PADDR, PWRITE and PWDATA SHALL remain stable from SETUP until the transfer ends.
REQ-020 ACCESS SHALL be held while PREADY=0.
REQ-021 On an edge in ACCESS with PREADY=1, the block SHALL return to IDLE and, for the owner only, pulse done for one cycle with err=PSLVERR and rdata=PRDATA for reads or 0 for writes.
REQ-022 With a zero-wait completer: req high in cycle 0 -> SETUP in cycle 1 -> ACCESS in cycle 2 -> done in cycle 3.
REQ-023 After each transfer the bus SHALL spend at least one cycle in IDLE, with no back-to-back SETUP.
REQ-024 Deassertion of req after the grant SHALL NOT abort the transfer; done is still issued.
REQ-025 A req still high in the done cycle SHALL be treated as a new request in the next IDLE evaluation.
REQ-026 The non-owner's done, err and rdata SHALL remain 0 throughout the transfer.
REQ-027 rdata and err SHALL be 0 in all cycles except the done cycle.

Reset
REQ-028 PRESETn low SHALL immediately, without waiting for PCLK, force:
- FSM to IDLE;
- PSEL, PENABLE, PWRITE, PADDR and PWDATA to 0;
- all done/err/rdata outputs to 0;
- the round-robin pointer to favour m0;
- the timeout counter to 0.
REQ-029 Reset asserted mid-transfer SHALL discard the transfer, with no done issued after release.
REQ-030 The first arbitration SHALL occur on the first PCLK edge after PRESETn rises.

Configuration
REQ-031 With APB_ARB2_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles.
- If TIMEOUT_CYCLES ACCESS cycles elapse with PREADY=0, the block SHALL return to IDLE.
- It SHALL pulse the owner's done with err=1 and rdata=0.
- The counter SHALL clear on every entry to SETUP.
REQ-032 Without APB_ARB2_TIMEOUT_EN, no counter logic SHALL exist, TIMEOUT_CYCLES SHALL be ignored, and ACCESS SHALL wait indefinitely for PREADY.

Structure
REQ-033 Package apb_arb2_pkg SHALL hold the FSM state typedef (IDLE, SETUP, ACCESS), the owner-ID typedef and the timeout counter width constant (16).
REQ-034 Round-robin winner selection SHALL be a sub-module apb_arb2_rr: inputs req[1:0] and last-grant; output winner ID and valid; purely combinational; the pointer register lives in apb_arb2.

Verification
REQ-035 Stimulus m0 write addr 0x004 data 0xA5 with a zero-wait slave SHALL give PSEL in cycle 1, PENABLE in cycle 2, m0_done in cycle 3 with m0_err=0.
REQ-036 Stimulus m0 and m1 reads raised in the same cycle, held high, with PRDATA 0x11 then 0x22, SHALL serve m0 first (m0_rdata=0x11), then m1 (m1_rdata=0x22), then m0 again; grants SHALL alternate.
REQ-037 Stimulus m1 read with PREADY low for 5 cycles and PSLVERR=1 SHALL hold ACCESS for 6 cycles, then give m1_done with m1_err=1 and m1_rdata=PRDATA.
REQ-038 Stimulus APB_ARB2_TIMEOUT_EN with TIMEOUT_CYCLES=4 and PREADY stuck low SHALL give done with err=1 and rdata=0 after 4 ACCESS cycles, then IDLE; without the macro, the bus SHALL stay in ACCESS.
REQ-039 Stimulus PRESETn pulled low during ACCESS SHALL drive PSEL/PENABLE to 0 asynchronously, with no done after release and m0 winning the next simultaneous request.
